// File: rtl/pc_redirect_controller.sv
// rtl/pc_redirect_controller.sv - fetch PC sequencing, redirect arbitration and pipeline squash control
module pc_redirect_controller #(
    parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imemReady,
    output logic        imemRequest,
    input  logic        hazardStall,
    input  logic        exceptionValid,
    input  logic        branchValid,
    input  logic        branchTaken,
    input  logic [31:0] branchPc,
    input  logic [15:0] branchOffset,
    input  logic        jumpValid,
    input  logic [1:0]  jumpType,
    input  logic [31:0] jumpPc,
    input  logic [25:0] jumpIndex,
    input  logic [31:0] jumpRegister,
    output logic        pcStall,
    output logic        pcJumpEnabled,
    output logic [31:0] pcJumpValue,
    output logic        flushFetch,
    output logic        flushDecode,
    output logic        redirectPending
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    // Set when the held redirect is an exception or branch, which also squashes ID/EX.
    logic        pend_decode_q, pend_decode_d;

    logic        take_branch;
    logic        req_valid;
    logic        req_decode;
    logic [31:0] req_target;
    logic [31:0] rel_target;
    logic [31:0] near_target;

    // Only the top nibble of the jump address contributes to a NEAR target.
    logic        unused_jump_pc;
    assign unused_jump_pc = ^jumpPc[27:0];

    // Redirect targets and priority winner: exception > taken branch > jump.
    always_comb begin
        take_branch = branchValid && branchTaken;
        rel_target  = branchPc + {{14{branchOffset[15]}}, branchOffset, 2'b00};
        near_target = {jumpPc[31:28], jumpIndex, 2'b00};
        req_valid   = exceptionValid || take_branch || jumpValid;
        req_decode  = exceptionValid || take_branch;
        req_target  = 32'h0;
        if (exceptionValid) begin
            req_target = EXC_VECTOR;
        end else if (take_branch) begin
            req_target = rel_target;
        end else if (jumpValid) begin
            req_target = (jumpType == 2'b00) ? near_target : jumpRegister;
        end
    end

    // Sequencing: outputs and next state from state, pending register and inputs.
    always_comb begin
        state_d         = state_q;
        pend_target_d   = pend_target_q;
        pend_decode_d   = pend_decode_q;
        imemRequest     = 1'b0;
        pcStall         = 1'b0;
        pcJumpEnabled   = 1'b0;
        pcJumpValue     = 32'h0;
        flushFetch      = 1'b0;
        flushDecode     = 1'b0;
        redirectPending = 1'b0;
        if (reset) begin
            pcStall       = 1'b1;
            state_d       = S_BOOT;
            pend_target_d = 32'h0;
            pend_decode_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    imemRequest = 1'b1;
                    if (req_valid) begin
                        flushFetch  = 1'b1;
                        flushDecode = req_decode;
                        if (imemReady) begin
                            pcJumpEnabled = 1'b1;
                            pcJumpValue   = req_target;
                        end else begin
                            pcStall       = 1'b1;
                            pend_target_d = req_target;
                            pend_decode_d = req_decode;
                            state_d       = S_HOLD;
                        end
                    end else begin
                        pcStall = !imemReady || hazardStall;
                    end
                end
                S_HOLD: begin
                    imemRequest     = 1'b1;
                    redirectPending = 1'b1;
                    flushFetch      = 1'b1;
                    pcStall         = !imemReady;
                    // A late exception supersedes whatever is held; other newcomers are wrong-path.
                    if (exceptionValid) begin
                        flushDecode   = 1'b1;
                        pend_target_d = EXC_VECTOR;
                        pend_decode_d = 1'b1;
                    end else begin
                        flushDecode = pend_decode_q;
                    end
                    if (imemReady) begin
                        pcJumpEnabled = 1'b1;
                        pcJumpValue   = exceptionValid ? EXC_VECTOR : pend_target_q;
                        pend_target_d = 32'h0;
                        pend_decode_d = 1'b0;
                        state_d       = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge clock) begin
        state_q       <= state_d;
        pend_target_q <= pend_target_d;
        pend_decode_q <= pend_decode_d;
    end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb/tb_pc_redirect_controller.sv - self-checking bench for pc_redirect_controller
module tb_pc_redirect_controller;

    localparam logic [31:0] EXC = 32'h00004180;

    logic        clock = 1'b0;
    logic        reset;
    logic        imemReady;
    logic        imemRequest;
    logic        hazardStall;
    logic        exceptionValid;
    logic        branchValid;
    logic        branchTaken;
    logic [31:0] branchPc;
    logic [15:0] branchOffset;
    logic        jumpValid;
    logic [1:0]  jumpType;
    logic [31:0] jumpPc;
    logic [25:0] jumpIndex;
    logic [31:0] jumpRegister;
    logic        pcStall;
    logic        pcJumpEnabled;
    logic [31:0] pcJumpValue;
    logic        flushFetch;
    logic        flushDecode;
    logic        redirectPending;

    pc_redirect_controller dut (
        .clock(clock), .reset(reset), .imemReady(imemReady), .imemRequest(imemRequest),
        .hazardStall(hazardStall), .exceptionValid(exceptionValid),
        .branchValid(branchValid), .branchTaken(branchTaken), .branchPc(branchPc),
        .branchOffset(branchOffset), .jumpValid(jumpValid), .jumpType(jumpType),
        .jumpPc(jumpPc), .jumpIndex(jumpIndex), .jumpRegister(jumpRegister),
        .pcStall(pcStall), .pcJumpEnabled(pcJumpEnabled), .pcJumpValue(pcJumpValue),
        .flushFetch(flushFetch), .flushDecode(flushDecode), .redirectPending(redirectPending)
    );

    always #5 clock = ~clock;

    // {imemRequest, pcStall, pcJumpEnabled, pcJumpValue, flushFetch, flushDecode, redirectPending}
    logic [37:0] act;
    assign act = {imemRequest, pcStall, pcJumpEnabled, pcJumpValue, flushFetch, flushDecode, redirectPending};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [37:0] pk(logic req, logic st, logic je, logic [31:0] v,
                                       logic ff, logic fd, logic rp);
        return {req, st, je, v, ff, fd, rp};
    endfunction

    task automatic chk(input string name, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got req=%b stall=%b je=%b val=%h ff=%b fd=%b rp=%b, want req=%b stall=%b je=%b val=%h ff=%b fd=%b rp=%b",
                     name, act[37], act[36], act[35], act[34:3], act[2], act[1], act[0],
                     exp[37], exp[36], exp[35], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic clear_inputs();
        exceptionValid = 0; branchValid = 0; branchTaken = 0; branchPc = 0; branchOffset = 0;
        jumpValid = 0; jumpType = 0; jumpPc = 0; jumpIndex = 0; jumpRegister = 0;
        hazardStall = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        exc;
        logic        bv;
        logic        bt;
        logic [31:0] bpc;
        logic [15:0] boff;
        logic        jv;
        logic [1:0]  jt;
        logic [31:0] jpc;
        logic [25:0] jidx;
        logic [31:0] jreg;
        logic        hz;
        logic        rdy;
        logic        st;
        logic        je;
        logic [31:0] val;
        logic        ff;
        logic        fd;
    } vec_t;

    vec_t vecs[13];

    // Reference model: abstract "booting" flag plus a queue of at most one held redirect.
    typedef struct {
        logic [31:0] target;
        logic        squash_decode;
    } redirect_t;

    redirect_t held_q[$];
    logic      m_boot;

    task automatic model_step(output logic [37:0] exp);
        logic        has;
        logic        severe;
        logic [31:0] tgt;
        redirect_t   r;
        exp = pk(0, 0, 0, 0, 0, 0, 0);
        has = 1'b1;
        severe = 1'b1;
        tgt = 32'h0;
        if (exceptionValid) tgt = EXC;
        else if (branchValid && branchTaken)
            tgt = branchPc + 32'($signed(branchOffset)) * 32'd4;
        else if (jumpValid) begin
            severe = 1'b0;
            tgt = (jumpType == 2'd0) ? ((jumpPc & 32'hF0000000) | (32'(jumpIndex) << 2)) : jumpRegister;
        end else has = 1'b0;

        if (reset) begin
            exp = pk(0, 1, 0, 0, 0, 0, 0);
            m_boot = 1'b1;
            held_q.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (held_q.size() == 0) begin
            if (has && imemReady) exp = pk(1, 0, 1, tgt, 1, severe, 0);
            else if (has) begin
                exp = pk(1, 1, 0, 0, 1, severe, 0);
                r.target = tgt; r.squash_decode = severe;
                held_q.push_back(r);
            end else exp = pk(1, !imemReady || hazardStall, 0, 0, 0, 0, 0);
        end else begin
            r = held_q[0];
            if (exceptionValid) begin
                r.target = EXC; r.squash_decode = 1'b1;
            end
            exp = pk(1, !imemReady, imemReady, imemReady ? r.target : 32'h0, 1,
                     exceptionValid || held_q[0].squash_decode, 1);
            held_q[0] = r;
            if (imemReady) held_q.delete();
        end
    endtask

    initial begin
        logic [37:0] exp;
        int seed_ok;

        vecs[0]  = '{0, 0, 0, 32'h0,        16'h0,    0, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 0, 32'h0,        0, 0};
        vecs[1]  = '{0, 1, 1, 32'h00003010, 16'hFFFC, 0, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 1, 32'h00003000, 1, 1};
        vecs[2]  = '{0, 1, 1, 32'h00003010, 16'hFFFC, 1, 2'd0, 32'h10003004, 26'h0000C40, 32'h0,        0, 1, 0, 1, 32'h00003000, 1, 1};
        vecs[3]  = '{0, 0, 0, 32'h0,        16'h0,    1, 2'd0, 32'h10003004, 26'h0000C40, 32'h0,        0, 1, 0, 1, 32'h10003100, 1, 0};
        vecs[4]  = '{0, 1, 0, 32'h00003010, 16'hFFFC, 0, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 0, 32'h0,        0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,        16'h0,    0, 2'd0, 32'h0,        26'h0,       32'h0,        1, 1, 1, 0, 32'h0,        0, 0};
        vecs[6]  = '{0, 1, 1, 32'h00003010, 16'hFFFC, 0, 2'd0, 32'h0,        26'h0,       32'h0,        1, 1, 0, 1, 32'h00003000, 1, 1};
        vecs[7]  = '{1, 1, 1, 32'h00003010, 16'hFFFC, 1, 2'd1, 32'h0,        26'h0,       32'h12345678, 0, 1, 0, 1, 32'h00004180, 1, 1};
        vecs[8]  = '{0, 0, 0, 32'h0,        16'h0,    1, 2'd1, 32'h10003004, 26'h0000C40, 32'hDEADBEE0, 0, 1, 0, 1, 32'hDEADBEE0, 1, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,        16'h0,    1, 2'd3, 32'h10003004, 26'h0000C40, 32'h00CAFE00, 0, 1, 0, 1, 32'h00CAFE00, 1, 0};
        vecs[10] = '{0, 0, 0, 32'h0,        16'h0,    0, 2'd0, 32'h0,        26'h0,       32'h0,        0, 0, 1, 0, 32'h0,        0, 0};
        vecs[11] = '{0, 1, 1, 32'h00000100, 16'h0010, 0, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 1, 32'h00000140, 1, 1};
        vecs[12] = '{0, 0, 0, 32'h0,        16'h0,    1, 2'd2, 32'hF0000008, 26'h3FFFFFF, 32'h00000044, 0, 1, 0, 1, 32'h00000044, 1, 0};

        // Reset and boot
        clear_inputs();
        reset = 1; imemReady = 1;
        next_cycle(); next_cycle();
        #2 chk("reset_outputs", pk(0, 1, 0, 0, 0, 0, 0));
        reset = 0;
        #2 chk("boot_cycle", pk(0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        #2 chk("first_fetch", pk(1, 0, 0, 0, 0, 0, 0));

        // Single-cycle FETCH vectors (none of these leaves FETCH)
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            exceptionValid = vecs[i].exc; branchValid = vecs[i].bv; branchTaken = vecs[i].bt;
            branchPc = vecs[i].bpc; branchOffset = vecs[i].boff; jumpValid = vecs[i].jv;
            jumpType = vecs[i].jt; jumpPc = vecs[i].jpc; jumpIndex = vecs[i].jidx;
            jumpRegister = vecs[i].jreg; hazardStall = vecs[i].hz; imemReady = vecs[i].rdy;
            #2 chk($sformatf("vec%0d", i),
                   pk(1, vecs[i].st, vecs[i].je, vecs[i].val, vecs[i].ff, vecs[i].fd, 0));
        end

        // FAR jump held across three not-ready cycles
        next_cycle(); clear_inputs();
        jumpValid = 1; jumpType = 1; jumpRegister = 32'h0000ABC0; imemReady = 0;
        #2 chk("far_enter_hold", pk(1, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            next_cycle(); clear_inputs(); imemReady = 0;
            #2 chk($sformatf("far_hold%0d", i), pk(1, 1, 0, 0, 1, 0, 1));
        end
        next_cycle(); imemReady = 1;
        #2 chk("far_apply", pk(1, 0, 1, 32'h0000ABC0, 1, 0, 1));
        next_cycle();
        #2 chk("far_after", pk(1, 0, 0, 0, 0, 0, 0));

        // Pending jump replaced by an exception in HOLD
        next_cycle(); jumpValid = 1; jumpType = 0; jumpPc = 32'h10003004; jumpIndex = 26'h0000C40; imemReady = 0;
        #2 chk("exc_enter_hold", pk(1, 1, 0, 0, 1, 0, 0));
        next_cycle(); clear_inputs(); exceptionValid = 1;
        #2 chk("exc_replace", pk(1, 1, 0, 0, 1, 1, 1));
        next_cycle(); clear_inputs();
        #2 chk("exc_held", pk(1, 1, 0, 0, 1, 1, 1));
        next_cycle(); imemReady = 1;
        #2 chk("exc_apply", pk(1, 0, 1, EXC, 1, 1, 1));

        // Exception and imemReady in the same HOLD cycle, over a pending branch
        next_cycle(); branchValid = 1; branchTaken = 1; branchPc = 32'h00003010; branchOffset = 16'hFFFC; imemReady = 0;
        #2 chk("br_enter_hold", pk(1, 1, 0, 0, 1, 1, 0));
        next_cycle(); clear_inputs(); exceptionValid = 1; imemReady = 1;
        #2 chk("hold_exc_ready", pk(1, 0, 1, EXC, 1, 1, 1));

        // Reset mid-HOLD drops the pending redirect
        next_cycle(); clear_inputs(); jumpValid = 1; jumpType = 1; jumpRegister = 32'h00007770; imemReady = 0;
        #2 chk("rst_enter_hold", pk(1, 1, 0, 0, 1, 0, 0));
        next_cycle(); clear_inputs(); reset = 1; imemReady = 1;
        #2 chk("rst_in_hold", pk(0, 1, 0, 0, 0, 0, 0));
        next_cycle(); reset = 0;
        #2 chk("rst_boot", pk(0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        #2 chk("rst_no_jump", pk(1, 0, 0, 0, 0, 0, 0));

        // Randomized run against the reference model
        m_boot = 1'b0;
        held_q.delete();
        seed_ok = 0;
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset          = ($urandom_range(0, 99) == 0);
            exceptionValid = ($urandom_range(0, 11) == 0);
            branchValid    = ($urandom_range(0, 3) == 0);
            branchTaken    = $urandom_range(0, 1);
            branchPc       = $urandom;
            branchOffset   = 16'($urandom);
            jumpValid      = ($urandom_range(0, 3) == 0);
            jumpType       = 2'($urandom_range(0, 3));
            jumpPc         = $urandom;
            jumpIndex      = 26'($urandom);
            jumpRegister   = $urandom;
            hazardStall    = ($urandom_range(0, 3) == 0);
            imemReady      = ($urandom_range(0, 9) < 6);
            model_step(exp);
            #2 chk($sformatf("rand%0d", i), exp);
            seed_ok++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_controller.md
# pc_redirect_controller

Sequencing controller for the fetch-stage program counter. It runs the instruction-memory fetch handshake, generates the counter's stall/jump/jumpValue controls, arbitrates the three redirect sources (exception, EX-stage branch, ID-stage jump) and computes their targets. It drives the squash signals for the IF/ID and ID/EX pipeline registers. When a redirect arrives while a fetch is outstanding, it holds that redirect until the fetch completes.

## Interface
- EXC_VECTOR, 32'h00004180, exception handler target
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imemReady  in  1  instruction memory returns fetch data this cycle
- imemRequest  out  1  fetch request for current PC
- hazardStall  in  1  decode hazard; freeze PC and IF/ID
- exceptionValid  in  1  exception redirect request
- branchValid  in  1  conditional branch resolved in EX
- branchTaken  in  1  branch outcome, qualified by branchValid
- branchPc  in  32  address following the branch (its PC+4)
- branchOffset  in  16  signed word offset
- jumpValid  in  1  jump decoded in ID
- jumpType  in  2  0 NEAR, 1 FAR; 2/3 treated as FAR
- jumpPc  in  32  address of the jump instruction
- jumpIndex  in  26  NEAR index field
- jumpRegister  in  32  FAR target
- pcStall  out  1  to counter stall
- pcJumpEnabled  out  1  to counter jumpEnabled
- pcJumpValue  out  32  to counter jumpValue
- flushFetch  out  1  squash IF/ID
- flushDecode  out  1  squash ID/EX
- redirectPending  out  1  a redirect is latched and not yet applied

## Operation
- Target arithmetic, all 32-bit modulo 2^32:
  - EXC = EXC_VECTOR.
  - RELATIVE = branchPc + (sign_extend(branchOffset) << 2).
  - NEAR = (jumpPc & 32'hF0000000) | (jumpIndex << 2).
  - FAR = jumpRegister.
- Request priority: exception > taken branch > jump. Only the winner is considered. A not-taken branch is no request.
- States:
  - BOOT: first cycle after reset release. pcStall=0, pcJumpEnabled=0, imemRequest=0. The counter advances to its reset vector. Always goes to FETCH.
  - FETCH: imemRequest=1. pcStall = !imemReady || (hazardStall && no request). A redirect overrides hazardStall.
    - Request with imemReady=1: apply it this cycle (pcJumpEnabled=1, pcJumpValue=target). Stay in FETCH.
    - Request with imemReady=0: latch target and class into the pending register and go to HOLD.
  - HOLD: imemRequest=1, redirectPending=1, pcStall = !imemReady.
    - On imemReady: apply the pending target and go to FETCH.
    - A new exception while in HOLD replaces a pending branch or jump.
    - Any other new request in HOLD is wrong-path and is dropped.
    - If imemReady and an exception arrive in the same cycle, the exception target is applied.
- Flushes:
  - flushFetch=1 in every cycle with a request, and in every HOLD cycle.
  - flushDecode=1 in the cycle an exception or taken branch is first seen, and in HOLD while the pending class is exception or branch.
  - A jump asserts flushFetch only.
- pcJumpEnabled=1 only in cycles where pcStall=0.

## Timing
- Reset (synchronous), effective at the next edge:
  - state = BOOT, pending cleared.
  - While reset is high: pcStall=1, pcJumpEnabled=0, pcJumpValue=0, imemRequest=0, flushFetch=0, flushDecode=0, redirectPending=0.
- Reset asserted mid-HOLD discards the pending redirect. No jump is issued afterwards.
- All outputs are combinational from state, pending register and current inputs. No output is registered beyond the state and pending flops.
- Latency: a request with imemReady=1 reaches the counter in the same cycle, and the counter holds the target after the next edge. In HOLD, application follows the first imemReady, with zero added cycles.
- When not applying a redirect, pcJumpValue = 0.

## Test plan
- Reset, then imemReady tied 1 -> one BOOT cycle with imemRequest=0 and pcStall=0, then imemRequest=1, pcStall=0, and no jump.
- branchValid=1, branchTaken=1, branchPc=32'h00003010, branchOffset=16'hFFFC, imemReady=1 -> pcJumpEnabled=1, pcJumpValue=32'h00003000, flushFetch=1, flushDecode=1.
- jumpValid=1, jumpType=NEAR, jumpPc=32'h10003004, jumpIndex=26'h0000C40, with a simultaneous taken branch -> the branch wins. The same jump alone yields pcJumpValue=32'h10003100 and flushDecode=0.
- FAR jump with imemReady=0 for 3 cycles -> HOLD, redirectPending=1, pcStall=1, flushFetch=1 for each of the 3 cycles. On the imemReady cycle, the jump is applied to jumpRegister.
- In HOLD with a pending jump, exceptionValid=1 -> pending replaced. When imemReady rises, pcJumpValue=32'h00004180 and flushDecode=1.
- hazardStall=1 with no request -> pcStall=1. hazardStall=1 together with a taken branch -> pcStall=0 and the branch is applied.
